// File: rtl/user_io_mux_if.sv
// Wishbone classic slave bus between the management core and the pad crossbar.
interface user_io_mux_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/user_io_mux.sv
// GPIO crossbar: routes each pad to one user core, with shadowed selects applied
// atomically by a commit that tri-states changing pads for a guard window first.
module user_io_mux #(
  parameter int unsigned N_CORES      = 2,
  parameter int unsigned NUM_IO       = 38,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  user_io_mux_if.slave                wb,
  input  logic [NUM_IO-1:0]           io_in,
  output logic [NUM_IO-1:0]           io_out,
  output logic [NUM_IO-1:0]           io_oeb,
  output logic [N_CORES*NUM_IO-1:0]   core_io_in,
  input  logic [N_CORES*NUM_IO-1:0]   core_io_out,
  input  logic [N_CORES*NUM_IO-1:0]   core_io_oeb,
  output logic                        busy
);

  localparam int unsigned MAX_PADS = 64;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_APPLY} state_t;

  state_t             state_q, next_state;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load_pending, do_apply;

  logic [3:0] shadow_q  [NUM_IO];
  logic [3:0] pending_q [NUM_IO];
  logic [3:0] active_q  [NUM_IO];
  logic [3:0] shadow_ext [MAX_PADS];
  logic [3:0] active_ext [MAX_PADS];

  logic        hit, req, wr, commit_req;
  logic [5:0]  word;
  logic [31:0] rd_data;
  logic        unused_adr;

  // Bus decode: one request per ack, so a held strobe is served every other cycle
  assign hit        = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req        = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~wb.wbs_ack_o;
  assign wr         = req & wb.wbs_we_i;
  assign word       = wb.wbs_adr_i[7:2];
  assign commit_req = wr & (word == 6'h10) & wb.wbs_dat_i[0];
  assign unused_adr = ^wb.wbs_adr_i[1:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= req;
      wb.wbs_dat_o <= (req && !wb.wbs_we_i) ? rd_data : 32'd0;
    end
  end

  // Read mux; padded banks make words past NUM_IO read as zero
  always_comb begin
    rd_data = '0;
    case (word[5:3])
      3'd0: for (int j = 0; j < 8; j++) rd_data[4*j +: 4] = shadow_ext[{word[2:0], 3'(j)}];
      3'd1: for (int j = 0; j < 8; j++) rd_data[4*j +: 4] = active_ext[{word[2:0], 3'(j)}];
      3'd2: if (word[2:0] == 3'd1) rd_data = {31'd0, busy};
      default: rd_data = '0;
    endcase
  end

  for (genvar e = 0; e < MAX_PADS; e++) begin : gen_ext
    if (e < NUM_IO) begin : gen_live
      assign shadow_ext[e] = shadow_q[e];
      assign active_ext[e] = active_q[e];
    end else begin : gen_pad_zero
      assign shadow_ext[e] = 4'd0;
      assign active_ext[e] = 4'd0;
    end
  end

  // Commit sequencer state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= next_state;
      cnt_q   <= cnt_d;
      busy    <= (next_state != S_IDLE);
    end
  end

  always_comb begin
    next_state   = state_q;
    cnt_d        = cnt_q;
    load_pending = 1'b0;
    do_apply     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit_req) begin
          load_pending = 1'b1;
          cnt_d        = '0;
          next_state   = (GUARD_CYCLES == 0) ? S_APPLY : S_GUARD;
        end
      end
      S_GUARD: begin
        if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) next_state = S_APPLY;
        else                                   cnt_d      = cnt_q + CNT_W'(1);
      end
      S_APPLY: begin
        do_apply   = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  for (genvar p = 0; p < NUM_IO; p++) begin : gen_pad
    logic [N_CORES-1:0] sel_hit, out_k, oeb_k;
    logic               guard;

    // Shadow select nibble, byte lane (p%8)/2 of word p/8
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        shadow_q[p] <= 4'd0;
      end else if (wr && (word == 6'(p / 8)) && wb.wbs_sel_i[(p % 8) / 2]) begin
        shadow_q[p] <= wb.wbs_dat_i[4*(p % 8) +: 4];
      end
    end

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        pending_q[p] <= 4'd0;
        active_q[p]  <= 4'd0;
      end else begin
        if (load_pending) pending_q[p] <= shadow_q[p];
        if (do_apply)     active_q[p]  <= pending_q[p];
      end
    end

    for (genvar k = 0; k < N_CORES; k++) begin : gen_core
      assign sel_hit[k]                = (active_q[p] == 4'(k));
      assign out_k[k]                  = core_io_out[k*NUM_IO + p];
      assign oeb_k[k]                  = core_io_oeb[k*NUM_IO + p];
      assign core_io_in[k*NUM_IO + p]  = sel_hit[k] & io_in[p];
    end

    // Only pads whose select is about to change are parked during the guard window
    assign guard     = (state_q == S_GUARD) && (pending_q[p] != active_q[p]);
    assign io_out[p] = ~guard & (|(sel_hit & out_k));
    assign io_oeb[p] = guard | ~(|sel_hit) | (|(sel_hit & oeb_k));
  end

endmodule

// File: doc/user_io_mux.md
# user_io_mux

Parametrised GPIO crossbar between the user-project wrapper pads and up to 16 user cores. Each pad is routed to exactly one core, selected at run time through Wishbone registers. New routings are staged in shadow registers and applied atomically by a commit. Affected pads are tri-stated for a guard window before the switch, so two cores never drive the same pad mid-change.

## Interface
- `N_CORES`, 2: number of attached cores, 1..16.
- `NUM_IO`, 38: number of pads routed, 1..64.
- `GUARD_CYCLES`, 4: cycles for which changing pads are tri-stated before a commit takes effect, 0..255.
- `BASE_ADDR`, 32'h3000_0000: Wishbone base. Address bits [31:8] must match.
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset: synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic slave controls.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_dat_o`  out  32  read data; registered; 0 when `wbs_ack_o`=0.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `io_in`  in  NUM_IO  pad inputs.
- `io_out`  out  NUM_IO  pad outputs.
- `io_oeb`  out  NUM_IO  pad output-enable, active-low.
- `core_io_in`  out  N_CORES*NUM_IO  per-core pad inputs; core k occupies slice [k*NUM_IO +: NUM_IO].
- `core_io_out`  in  N_CORES*NUM_IO  per-core pad outputs.
- `core_io_oeb`  in  N_CORES*NUM_IO  per-core pad output-enables.
- `busy`  out  1  commit sequence in progress.

## Operation
- **Select fields.** Each pad p has a 4-bit select field in both the shadow bank and the active bank.
  - Packing: 8 pads per 32-bit word; pad p uses word p/8, bits [4*(p%8)+3 : 4*(p%8)].
- **Register map** (offset from `BASE_ADDR`):
  - 0x00–0x1C: shadow select words. Read/write; byte enables honoured.
  - 0x20–0x3C: active select words. Read-only.
  - 0x40: CTRL. Writing bit0=1 starts a commit. Reads return 0.
  - 0x44: STATUS. Read-only; bit0 = `busy`, other bits 0.
  - Words beyond ceil(NUM_IO/8) and unmapped offsets: acked, read 0, writes ignored.
  - Bits belonging to pads ≥ NUM_IO read 0.
- **Wishbone handshake.**
  - `wbs_ack_o` pulses for exactly one cycle, on the cycle after `cyc&stb` is sampled with `ack`=0.
  - A held strobe therefore gets an ack every second cycle.
  - The write takes effect on the ack edge.
- **Routing** (combinational, from the active bank):
  - Active select s < N_CORES: `io_out[p]`/`io_oeb[p]` follow core s, pad p. `core_io_in[s][p]` = `io_in[p]`; every other core sees 0 on pad p.
  - Active select ≥ N_CORES: `io_out[p]`=0, `io_oeb[p]`=1; all cores see 0 on pad p.
- **Commit FSM: IDLE → GUARD → APPLY → IDLE.**
  - IDLE: a CTRL bit0 write snapshots the shadow bank into a pending bank, then goes to GUARD (or straight to APPLY if GUARD_CYCLES=0).
  - GUARD: for every pad whose pending select ≠ active select, force `io_oeb`=1 and `io_out`=0. Count GUARD_CYCLES cycles.
  - APPLY: active ← pending (one cycle), then return to IDLE.
  - `busy` = 1 whenever the FSM is not in IDLE.
  - Unchanged pads are never disturbed.
- **During a commit.**
  - CTRL writes while `busy` are acked and ignored; the request is not queued.
  - Shadow writes while `busy` update the shadow bank only; the pending bank is unaffected.
- **Reset.** Shadow, pending and active banks clear to 0, so all pads route to core 0. FSM → IDLE, `busy`=0, `wbs_ack_o`=0, `wbs_dat_o`=0. Pad outputs then follow core 0 combinationally.
- **Reset mid-commit.** Abandons the sequence; the active bank returns to 0 and no partial apply occurs.

## Timing
- **Commit write acked at edge E.**
  - `busy`=1 and guard forcing start from E+1.
  - GUARD occupies E+1 … E+GUARD_CYCLES.
  - APPLY edge is E+GUARD_CYCLES+1. New routing is visible after that edge, and `busy`=0 from the same edge.
- **GUARD_CYCLES=0:** `busy` is high for exactly one cycle; the new routing is visible after edge E+1.
- **Register reads:** data is returned with the ack, one cycle after request.
- **Pad/core paths:** combinational; no added latency.

## Test plan
- **Reset defaults.** Assert reset, drive core0 `io_out`=all-ones with `io_oeb`=0 → `io_out`=all-ones, `io_oeb`=0, STATUS reads 0, both shadow and active word 0 read 0.
- **Basic commit.** Write shadow word0 = 0x0000_0010 (pad1 → core1), then CTRL=1 with GUARD_CYCLES=4 → pad1 `io_oeb`=1 for 4 cycles while pad0 is undisturbed; `busy` is high for 5 cycles; afterwards pad1 follows core1 and active word0 reads 0x10.
- **Out-of-range select.** With N_CORES=2, select 0xF for pad 3 and commit → `io_oeb[3]`=1, `io_out[3]`=0; `core_io_in` bit 3 is 0 for both cores.
- **Writes during busy.** Issue CTRL=1 while busy, then a shadow write → the first commit applies only the snapshot taken at its start; the second CTRL write is ignored; the shadow read-back shows the new value.
- **Byte enables and unmapped space.**
  - Write 0xFFFF_FFFF with `wbs_sel_i`=4'b0010 → shadow word reads 0x0000_FF00.
  - Access offset 0x80 → acked, reads 0.
- **Reset mid-GUARD.** Assert reset 2 cycles into GUARD → `busy`=0 next cycle, active bank = 0, no pad switches to the new core.
